// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the receive-path header parsers:
//   - IPv4 constants (version, minimum IHL, default accepted protocol)
//   - byte offsets of the IPv4 header fields the parser looks at
//   - the IPv4 receive FSM state type
//   - the one's-complement carry fold used by the checksum accumulator
// ----------------------------------------------------------------------------
package eth_pkg;

    localparam logic [3:0] IP_VERSION    = 4'd4;
    localparam logic [3:0] IP_IHL_MIN    = 4'd5;
    localparam logic [7:0] PROTO_UDP_DEF = 8'd17;

    // Byte offsets from the first IPv4 header byte
    localparam logic [5:0] OFF_LEN   = 6'd2;
    localparam logic [5:0] OFF_FRAG  = 6'd6;
    localparam logic [5:0] OFF_PROTO = 6'd9;
    localparam logic [5:0] OFF_SRC   = 6'd12;
    localparam logic [5:0] OFF_DST   = 6'd16;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DONE   = 2'd2,
        ST_HOLD   = 2'd3
    } ip_rx_state_t;

    // Fold a 21-bit word sum to 16 bits with end-around carry, applied twice.
    // After the first fold the value is at most 0xFFFF + 0x1F, so the second
    // fold can never carry out again.
    function automatic logic [15:0] csum_fold(input logic [20:0] sum);
        logic [16:0] f1;
        f1 = {1'b0, sum[15:0]} + {12'd0, sum[20:16]};
        return f1[15:0] + {15'd0, f1[16]};
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// ----------------------------------------------------------------------------
// ip_csum_acc
// 16-bit one's-complement word accumulator. Words are summed into a 21-bit
// register, which holds up to 31 full-scale words (a 60-byte header is 30
// words). o_fold is the folded sum of the register plus the word currently
// on i_word, so the final word can be folded in without an extra cycle.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   i_clr    synchronous clear of the accumulator
//   i_add    add i_word into the accumulator this cycle
//   i_word   16-bit word (high byte = even byte index)
//   o_fold   fold(accumulator + i_word), 16 bits
// ----------------------------------------------------------------------------
module ip_csum_acc (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_add,
    input  logic [15:0] i_word,
    output logic [15:0] o_fold
);
    import eth_pkg::*;

    logic [20:0] r_acc;
    logic [20:0] w_sum;

    assign w_sum  = r_acc + {5'd0, i_word};
    assign o_fold = csum_fold(w_sum);

    // Word accumulator: clear, add, or hold
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_acc <= 21'd0;
        end else if (i_add) begin
            r_acc <= w_sum;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/ip_header_rx.sv
// ----------------------------------------------------------------------------
// ip_header_rx
// IPv4 header parser feeding the UDP header stage. Starts on the
// eth_header_done pulse (IP byte 0 on data_in), captures source IP and total
// length, checks version/IHL, fragmentation, protocol, destination IP and
// header checksum, and pulses ip_header_done on the first byte after the
// header together with the ip_header_valid verdict, which then holds until
// data_valid drops.
// Ports:
//   aclk             clock
//   aresetn          synchronous active-low reset
//   data_in          frame byte stream
//   data_valid       high for whole frame; low = synchronous abort / re-arm
//   eth_header_done  pulse coincident with IP header byte 0
//   ip_d             local IP address (destination must match)
//   ip_s             captured source IP (not reset)
//   ip_len           captured total length (not reset)
//   ip_header_done   pulse on first byte after the IP header
//   ip_header_valid  header verdict, qualified from the done cycle
// ----------------------------------------------------------------------------
module ip_header_rx #(
    parameter bit         CHECK_CSUM = 1'b1,
    parameter logic [7:0] PROTO_UDP  = eth_pkg::PROTO_UDP_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        eth_header_done,
    input  logic [31:0] ip_d,
    output logic [31:0] ip_s,
    output logic [15:0] ip_len,
    output logic        ip_header_done,
    output logic        ip_header_valid
);
    import eth_pkg::*;

    ip_rx_state_t r_state;
    logic [5:0]   r_cnt;      // index of the byte currently on data_in
    logic [3:0]   r_ihl;
    logic [7:0]   r_hi;       // pending high byte of the current word
    logic         r_ok;       // all field checks so far passed

    logic         w_run;
    logic [5:0]   w_last_idx;
    logic         w_is_last;
    logic         w_start_ok;
    logic         w_csum_add;
    logic         w_csum_clr;
    logic [15:0]  w_csum_fold;
    logic         w_csum_ok;
    logic         w_byte_ok;
    logic         w_verdict;

    // data_valid low behaves exactly like reset
    assign w_run      = aresetn & data_valid;
    assign w_last_idx = {r_ihl, 2'b00} - 6'd1;
    assign w_is_last  = (r_state == ST_HEADER) && (r_cnt == w_last_idx);
    assign w_start_ok = (data_in[7:4] == IP_VERSION) && (data_in[3:0] >= IP_IHL_MIN);

    // Odd byte index completes a word; the last word is folded in
    // combinationally via o_fold instead of being registered.
    assign w_csum_add = (r_state == ST_HEADER) && r_cnt[0] && !w_is_last;
    assign w_csum_clr = (r_state != ST_HEADER);
    assign w_csum_ok  = (w_csum_fold == 16'hFFFF);

    ip_csum_acc u_csum (
        .i_clk   (aclk),
        .i_rst_n (w_run),
        .i_clr   (w_csum_clr),
        .i_add   (w_csum_add),
        .i_word  ({r_hi, data_in}),
        .o_fold  (w_csum_fold)
    );

    // Per-byte field check for the byte currently on data_in
    always_comb begin
        w_byte_ok = 1'b1;
        if (r_state == ST_HEADER) begin
            case (r_cnt)
                OFF_FRAG:         w_byte_ok = !data_in[5] && (data_in[4:0] == 5'd0);
                OFF_FRAG + 6'd1:  w_byte_ok = (data_in == 8'd0);
                OFF_PROTO:        w_byte_ok = (data_in == PROTO_UDP);
                OFF_DST:          w_byte_ok = (data_in == ip_d[31:24]);
                OFF_DST + 6'd1:   w_byte_ok = (data_in == ip_d[23:16]);
                OFF_DST + 6'd2:   w_byte_ok = (data_in == ip_d[15:8]);
                OFF_DST + 6'd3:   w_byte_ok = (data_in == ip_d[7:0]);
                default:          w_byte_ok = 1'b1;
            endcase
        end else begin
            w_byte_ok = 1'b1;
        end
    end

    assign w_verdict = r_ok && w_byte_ok && (w_csum_ok || !CHECK_CSUM);

    // Header FSM with registered done/valid outputs
    always_ff @(posedge aclk) begin
        if (!w_run) begin
            r_state         <= ST_WAIT;
            r_cnt           <= 6'd0;
            r_ihl           <= 4'd0;
            r_hi            <= 8'd0;
            r_ok            <= 1'b0;
            ip_header_done  <= 1'b0;
            ip_header_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    ip_header_done  <= 1'b0;
                    ip_header_valid <= 1'b0;
                    if (eth_header_done && w_start_ok) begin
                        r_state <= ST_HEADER;
                        r_cnt   <= 6'd1;
                        r_ihl   <= data_in[3:0];
                        r_hi    <= data_in;
                        r_ok    <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_HEADER: begin
                    if (w_is_last) begin
                        r_state         <= ST_DONE;
                        ip_header_done  <= 1'b1;
                        ip_header_valid <= w_verdict;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        r_ok  <= r_ok && w_byte_ok;
                        if (!r_cnt[0]) begin
                            r_hi <= data_in;
                        end else begin
                            r_hi <= r_hi;
                        end
                    end
                end
                ST_DONE: begin
                    ip_header_done <= 1'b0;
                    r_state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    ip_header_done <= 1'b0;
                    r_state        <= ST_HOLD;
                end
                default: begin
                    r_state         <= ST_WAIT;
                    ip_header_done  <= 1'b0;
                    ip_header_valid <= 1'b0;
                end
            endcase
        end
    end

    // Field capture; deliberately not reset so the last frame's values persist
    always_ff @(posedge aclk) begin
        if (w_run && (r_state == ST_HEADER)) begin
            case (r_cnt)
                OFF_LEN:         ip_len[15:8] <= data_in;
                OFF_LEN + 6'd1:  ip_len[7:0]  <= data_in;
                OFF_SRC:         ip_s[31:24]  <= data_in;
                OFF_SRC + 6'd1:  ip_s[23:16]  <= data_in;
                OFF_SRC + 6'd2:  ip_s[15:8]   <= data_in;
                OFF_SRC + 6'd3:  ip_s[7:0]    <= data_in;
                default: begin
                    ip_s   <= ip_s;
                    ip_len <= ip_len;
                end
            endcase
        end else begin
            ip_s   <= ip_s;
            ip_len <= ip_len;
        end
    end

endmodule

// File: tb/tb_ip_header_rx.sv
module tb_ip_header_rx;

    typedef struct packed {
        logic [191:0] hdr;       // byte i at hdr[191-8*i -: 8]
        logic [5:0]   n;         // header length in bytes
        logic [31:0]  ipd;
        logic         exp_done;
        logic         exp_valid;
        logic         exp_valid_nocs;
        logic [31:0]  exp_s;
        logic [15:0]  exp_len;
    } row_t;

    typedef struct {
        int          cyc;
        logic        v;
        logic        vn;
        logic [31:0] s;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        eth_done;
    logic [31:0] ipd;
    logic [31:0] ip_s_a, ip_s_b;
    logic [15:0] ip_len_a, ip_len_b;
    logic        done_a, done_b, valid_a, valid_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ip_header_rx #(.CHECK_CSUM(1'b1), .PROTO_UDP(8'd17)) dut (
        .aclk(clk), .aresetn(aresetn), .data_in(data_in), .data_valid(data_valid),
        .eth_header_done(eth_done), .ip_d(ipd), .ip_s(ip_s_a), .ip_len(ip_len_a),
        .ip_header_done(done_a), .ip_header_valid(valid_a)
    );

    ip_header_rx #(.CHECK_CSUM(1'b0), .PROTO_UDP(8'd17)) dut_nocs (
        .aclk(clk), .aresetn(aresetn), .data_in(data_in), .data_valid(data_valid),
        .eth_header_done(eth_done), .ip_d(ipd), .ip_s(ip_s_b), .ip_len(ip_len_b),
        .ip_header_done(done_b), .ip_header_valid(valid_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] setb(input logic [191:0] h, input int i, input logic [7:0] v);
        h[191-8*i -: 8] = v;
        return h;
    endfunction

    // Recompute the header checksum over the first n bytes
    function automatic logic [191:0] fixcs(input logic [191:0] h, input int n);
        logic [31:0] s;
        h = setb(h, 10, 8'h00);
        h = setb(h, 11, 8'h00);
        s = 32'd0;
        for (int i = 0; i < n; i += 2)
            s += {16'd0, h[191-8*i -: 8], h[191-8*(i+1) -: 8]};
        while (s[31:16] != 16'd0)
            s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        h = setb(h, 10, ~s[15:8]);
        h = setb(h, 11, ~s[7:0]);
        return h;
    endfunction

    function automatic row_t mk(input logic [191:0] h, input int n, input logic [31:0] ip,
                                input bit d, input bit v, input bit vn,
                                input logic [31:0] s, input logic [15:0] len);
        row_t r;
        r.hdr = h; r.n = 6'(n); r.ipd = ip; r.exp_done = d; r.exp_valid = v;
        r.exp_valid_nocs = vn; r.exp_s = s; r.exp_len = len;
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done_a || done_b) begin
            chk("done_coincide", {31'd0, done_b}, {31'd0, done_a});
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("valid_at_done", {31'd0, valid_a}, {31'd0, e.v});
                chk("valid_nocs_at_done", {31'd0, valid_b}, {31'd0, e.vn});
                chk("ip_s", ip_s_a, e.s);
                chk("ip_len", {16'd0, ip_len_a}, {16'd0, e.len});
            end
        end
    end

    // Drive one frame: header, 4 payload bytes (with a stray eth pulse), then idle.
    // abort_at >= 0 drops data_valid at that byte index instead.
    task automatic run_row(input row_t r, input int abort_at);
        int n;
        logic ev, evn;
        exp_t e;
        n = int'(r.n);
        @(negedge clk);
        ipd = r.ipd;
        if (r.exp_done && abort_at < 0) begin
            e.cyc = cyc + n; e.v = r.exp_valid; e.vn = r.exp_valid_nocs;
            e.s = r.exp_s; e.len = r.exp_len;
            sb.push_back(e);
        end
        for (int i = 0; i < n + 4; i++) begin
            if (i > 0) @(negedge clk);
            if (abort_at >= 0 && i == abort_at) break;
            if (i > 0 && i != n) begin
                ev  = (r.exp_done && i > n) ? r.exp_valid : 1'b0;
                evn = (r.exp_done && i > n) ? r.exp_valid_nocs : 1'b0;
                chk("valid_level", {31'd0, valid_a}, {31'd0, ev});
                chk("valid_nocs_level", {31'd0, valid_b}, {31'd0, evn});
            end
            data_valid = 1'b1;
            eth_done   = (i == 0) || (i == n + 2);
            data_in    = (i < n) ? r.hdr[191-8*i -: 8] : 8'(8'hA0 + i);
        end
        if (abort_at < 0) begin
            @(negedge clk);
            chk("valid_hold_end", {31'd0, valid_a}, {31'd0, r.exp_done & r.exp_valid});
        end
        data_valid = 1'b0;
        eth_done   = 1'b0;
        data_in    = 8'h00;
        @(negedge clk);
        chk("valid_after_drop", {31'd0, valid_a}, 32'd0);
        chk("done_after_drop", {31'd0, done_a}, 32'd0);
        if (sb.size() != 0) begin
            chk("missing_done", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        row_t rows[11];
        logic [191:0] base;
        logic [191:0] h;

        base = {160'h4500002E_00004000_4011B963_C0A80001_C0A8000A, 32'h0};

        rows[0]  = mk(base, 20, 32'hC0A8000A, 1, 1, 1, 32'hC0A80001, 16'h002E);
        rows[1]  = mk(setb(base, 11, 8'h64), 20, 32'hC0A8000A, 1, 0, 1, 32'hC0A80001, 16'h002E);
        rows[2]  = mk(fixcs(setb(base, 19, 8'h0B), 20), 20, 32'hC0A8000A, 1, 0, 0, 32'hC0A80001, 16'h002E);
        rows[3]  = mk(fixcs(setb(base, 9, 8'h06), 20), 20, 32'hC0A8000A, 1, 0, 0, 32'hC0A80001, 16'h002E);
        rows[4]  = mk(fixcs(setb(base, 6, 8'h20), 20), 20, 32'hC0A8000A, 1, 0, 0, 32'hC0A80001, 16'h002E);
        h = setb(base, 0, 8'h46);
        h = setb(h, 3, 8'h32);
        h = setb(h, 20, 8'h01); h = setb(h, 21, 8'h02);
        h = setb(h, 22, 8'h03); h = setb(h, 23, 8'h04);
        rows[5]  = mk(fixcs(h, 24), 24, 32'hC0A8000A, 1, 1, 1, 32'hC0A80001, 16'h0032);
        rows[6]  = mk(setb(base, 0, 8'h65), 20, 32'hC0A8000A, 0, 0, 0, 32'h0, 16'h0);
        rows[7]  = mk(setb(base, 0, 8'h44), 20, 32'hC0A8000A, 0, 0, 0, 32'h0, 16'h0);
        rows[8]  = mk(fixcs(setb(base, 7, 8'h01), 20), 20, 32'hC0A8000A, 1, 0, 0, 32'hC0A80001, 16'h002E);
        h = setb(base, 6, 8'h00);
        h = setb(h, 12, 8'h0A); h = setb(h, 13, 8'h00);
        h = setb(h, 14, 8'h00); h = setb(h, 15, 8'h05);
        rows[9]  = mk(fixcs(h, 20), 20, 32'hC0A8000A, 1, 1, 1, 32'h0A000005, 16'h002E);
        rows[10] = mk(base, 20, 32'hC0A8000B, 1, 0, 0, 32'hC0A80001, 16'h002E);

        aresetn    = 1'b0;
        data_valid = 1'b0;
        eth_done   = 1'b0;
        data_in    = 8'h00;
        ipd        = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_done", {31'd0, done_a}, 32'd0);
        chk("reset_valid", {31'd0, valid_a}, 32'd0);
        chk("reset_valid_nocs", {31'd0, valid_b}, 32'd0);
        aresetn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 11; k++)
            run_row(rows[k], -1);

        // Abort at byte 10, then a clean frame must parse normally
        run_row(rows[0], 10);
        run_row(rows[0], -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
